// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Walks each instruction through fetch, decode, execute, memory and
// writeback. It drives the datapath selects, the write strobes and the
// immediate-variant select. Memory latency is absorbed by holding the
// current state until mem_ready is seen.
module multicycle_ctrl #(
    parameter bit TRAP_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [2:0]  imm_type,
    output logic        illegal,
    output logic        instr_done,
    output logic [3:0]  state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_AUIPC    = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_store;
    logic       bad_branch;
    logic       br_taken;

    assign opcode     = instr[6:0];
    assign funct3     = instr[14:12];
    assign is_store   = (opcode == OP_STORE);
    // funct3 010/011 are not branch encodings and divert to TRAP.
    assign bad_branch = (funct3 == 3'b010) || (funct3 == 3'b011);
    assign state      = state_q;

    // Only opcode and funct3 steer the controller; the rest of the word
    // belongs to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    // Branch condition evaluation from the ALU compare flags.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = ~lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = ~ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // State register; reset returns to FETCH, abandoning any instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory states hold until mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = is_store ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = bad_branch ? S_TRAP : S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_LUI:      state_d = S_ALUWB;
            S_AUIPC:    state_d = S_ALUWB;
            S_TRAP:     state_d = TRAP_HALT ? S_TRAP : S_FETCH;
            default:    state_d = S_TRAP;
        endcase
    end

    // Output decode from the current state, with strobes squashed during reset.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        imm_type   = 3'b000;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight to the PC while the word lands in IR.
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                // Precompute old PC + immediate as the branch/JAL target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_type  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_type  = is_store ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write   = br_taken & ~bad_branch;
                instr_done = ~bad_branch;
            end
            S_JAL: begin
                // Target from ALU-out goes to PC; ALU forms old PC + 4 for rd.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_type  = 3'b100;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_type  = 3'b100;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the control outputs against hand-derived values.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        zero, lt, ltu, mem_ready;

    // Instance with TRAP_HALT=1 (main checks)
    logic        h_pc_write, h_ir_write, h_adr_src, h_mem_read, h_mem_write, h_reg_write;
    logic [1:0]  h_result_src, h_alu_src_a, h_alu_src_b, h_alu_op;
    logic [2:0]  h_imm_type;
    logic        h_illegal, h_instr_done;
    logic [3:0]  h_state;

    // Instance with TRAP_HALT=0 (trap-recovery checks)
    logic        r_pc_write, r_ir_write, r_adr_src, r_mem_read, r_mem_write, r_reg_write;
    logic [1:0]  r_result_src, r_alu_src_a, r_alu_src_b, r_alu_op;
    logic [2:0]  r_imm_type;
    logic        r_illegal, r_instr_done;
    logic [3:0]  r_state;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.TRAP_HALT(1'b1)) dut_halt (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready),
        .pc_write(h_pc_write), .ir_write(h_ir_write), .adr_src(h_adr_src),
        .mem_read(h_mem_read), .mem_write(h_mem_write), .reg_write(h_reg_write),
        .result_src(h_result_src), .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b),
        .alu_op(h_alu_op), .imm_type(h_imm_type), .illegal(h_illegal),
        .instr_done(h_instr_done), .state(h_state)
    );

    multicycle_ctrl #(.TRAP_HALT(1'b0)) dut_run (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready),
        .pc_write(r_pc_write), .ir_write(r_ir_write), .adr_src(r_adr_src),
        .mem_read(r_mem_read), .mem_write(r_mem_write), .reg_write(r_reg_write),
        .result_src(r_result_src), .alu_src_a(r_alu_src_a), .alu_src_b(r_alu_src_b),
        .alu_op(r_alu_op), .imm_type(r_imm_type), .illegal(r_illegal),
        .instr_done(r_instr_done), .state(r_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs/checks then happen 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Set mem_ready for the current cycle, let outputs settle, check state.
    task automatic cyc(input logic mr, input logic [3:0] st, input string tag);
        mem_ready = mr;
        #1;
        check({tag, "_state"}, {28'd0, h_state}, {28'd0, st});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0000_0013; zero = 0; lt = 0; ltu = 0; mem_ready = 1'b1;
        #1;
        // Reset state: FETCH with strobes forced low even though mem_ready=1
        check("rst_state",  {28'd0, h_state}, 32'd0);
        check("rst_ir",     {31'd0, h_ir_write}, 32'd0);
        check("rst_pc",     {31'd0, h_pc_write}, 32'd0);
        check("rst_mrd",    {31'd0, h_mem_read}, 32'd0);
        step();
        rst = 1'b0;

        // Load that gets interrupted by reset while waiting in MEMREAD
        instr = 32'h0000_A083;
        cyc(1'b1, 4'd0, "lwA_f");
        check("lwA_f_ir",  {31'd0, h_ir_write}, 32'd1);
        check("lwA_f_pc",  {31'd0, h_pc_write}, 32'd1);
        check("lwA_f_b",   {30'd0, h_alu_src_b}, 32'd2);
        check("lwA_f_res", {30'd0, h_result_src}, 32'd2);
        step();
        cyc(1'b1, 4'd1, "lwA_d");
        check("lwA_d_imm", {29'd0, h_imm_type}, 32'd2);
        step();
        cyc(1'b1, 4'd2, "lwA_ma");
        step();
        cyc(1'b0, 4'd3, "lwA_mr");
        check("lwA_mr_rd", {31'd0, h_mem_read}, 32'd1);
        #1;
        rst = 1'b1;
        instr = 32'h0000_0013;
        mem_ready = 1'b1;
        #1;
        check("midrst_state", {28'd0, h_state}, 32'd0);
        check("midrst_strb",
              {26'd0, h_pc_write, h_ir_write, h_mem_read, h_mem_write, h_reg_write, h_instr_done},
              32'd0);
        step();
        rst = 1'b0;
        $display("txn: reset during MEMREAD");

        // addi x0,x0,0 after reset
        cyc(1'b1, 4'd0, "addi_f");
        step();
        cyc(1'b1, 4'd1, "addi_d");
        step();
        cyc(1'b1, 4'd7, "addi_x");
        check("addi_x_op",  {30'd0, h_alu_op}, 32'd2);
        check("addi_x_a",   {30'd0, h_alu_src_a}, 32'd2);
        check("addi_x_b",   {30'd0, h_alu_src_b}, 32'd1);
        step();
        cyc(1'b1, 4'd8, "addi_wb");
        check("addi_wb_rw",   {31'd0, h_reg_write}, 32'd1);
        check("addi_wb_done", {31'd0, h_instr_done}, 32'd1);
        step();
        $display("txn: addi");

        // lw with 3 wait cycles: 8 cycles total
        instr = 32'h0000_A083;
        cyc(1'b1, 4'd0, "lw_f");
        step();
        cyc(1'b1, 4'd1, "lw_d");
        step();
        cyc(1'b1, 4'd2, "lw_ma");
        check("lw_ma_imm", {29'd0, h_imm_type}, 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'd3, "lw_wait");
            check("lw_wait_rd",  {31'd0, h_mem_read}, 32'd1);
            check("lw_wait_adr", {31'd0, h_adr_src}, 32'd1);
            step();
        end
        cyc(1'b1, 4'd3, "lw_mr");
        check("lw_mr_done", {31'd0, h_instr_done}, 32'd0);
        step();
        cyc(1'b1, 4'd4, "lw_wb");
        check("lw_wb_res",  {30'd0, h_result_src}, 32'd1);
        check("lw_wb_rw",   {31'd0, h_reg_write}, 32'd1);
        check("lw_wb_done", {31'd0, h_instr_done}, 32'd1);
        step();
        cyc(1'b1, 4'd0, "lw_next");
        $display("txn: lw with 3 wait cycles");

        // sw x2,0(x1)
        instr = 32'h0020_A023;
        step();
        cyc(1'b1, 4'd1, "sw_d");
        step();
        cyc(1'b1, 4'd2, "sw_ma");
        check("sw_ma_imm", {29'd0, h_imm_type}, 32'd1);
        check("sw_ma_rw",  {31'd0, h_reg_write}, 32'd0);
        step();
        cyc(1'b0, 4'd5, "sw_wait");
        check("sw_wait_wr",   {31'd0, h_mem_write}, 32'd1);
        check("sw_wait_done", {31'd0, h_instr_done}, 32'd0);
        step();
        cyc(1'b1, 4'd5, "sw_mw");
        check("sw_mw_wr",   {31'd0, h_mem_write}, 32'd1);
        check("sw_mw_adr",  {31'd0, h_adr_src}, 32'd1);
        check("sw_mw_done", {31'd0, h_instr_done}, 32'd1);
        check("sw_mw_rw",   {31'd0, h_reg_write}, 32'd0);
        step();
        cyc(1'b1, 4'd0, "sw_next");
        $display("txn: sw");

        // beq taken then not taken
        instr = 32'h0020_8463;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            step();
            cyc(1'b1, 4'd1, "beq_d");
            step();
            cyc(1'b1, 4'd9, "beq_br");
            check(k == 0 ? "beq_t_pcw" : "beq_n_pcw", {31'd0, h_pc_write}, k == 0 ? 32'd1 : 32'd0);
            check("beq_br_op",   {30'd0, h_alu_op}, 32'd1);
            check("beq_br_done", {31'd0, h_instr_done}, 32'd1);
            step();
            cyc(1'b1, 4'd0, "beq_next");
            $display("txn: beq zero=%0d", zero);
        end

        // bgeu (funct3=111) with ltu=0 -> taken
        instr = 32'h0020_F463; ltu = 1'b0; zero = 1'b0;
        step();
        step();
        cyc(1'b1, 4'd9, "bgeu_br");
        check("bgeu_pcw", {31'd0, h_pc_write}, 32'd1);
        step();
        $display("txn: bgeu");

        // Branch with funct3=010 -> TRAP
        instr = 32'h0020_A463;
        cyc(1'b1, 4'd0, "bbad_f");
        step();
        step();
        cyc(1'b1, 4'd9, "bbad_br");
        check("bbad_pcw",  {31'd0, h_pc_write}, 32'd0);
        check("bbad_done", {31'd0, h_instr_done}, 32'd0);
        step();
        cyc(1'b1, 4'd14, "bbad_trap");
        check("bbad_ill", {31'd0, h_illegal}, 32'd1);
        $display("txn: branch funct3=010");
        do_reset();

        // JAL
        instr = 32'h0080_00EF;
        cyc(1'b1, 4'd0, "jal_f");
        step();
        cyc(1'b1, 4'd1, "jal_d");
        check("jal_d_imm", {29'd0, h_imm_type}, 32'd3);
        step();
        cyc(1'b1, 4'd10, "jal_j");
        check("jal_j_pcw", {31'd0, h_pc_write}, 32'd1);
        check("jal_j_a",   {30'd0, h_alu_src_a}, 32'd1);
        check("jal_j_b",   {30'd0, h_alu_src_b}, 32'd2);
        step();
        cyc(1'b1, 4'd8, "jal_wb");
        check("jal_wb_rw", {31'd0, h_reg_write}, 32'd1);
        step();
        $display("txn: jal");

        // JALR
        instr = 32'h0000_80E7;
        cyc(1'b1, 4'd0, "jalr_f");
        step();
        cyc(1'b1, 4'd1, "jalr_d");
        step();
        cyc(1'b1, 4'd11, "jalr_r");
        check("jalr_r_a",   {30'd0, h_alu_src_a}, 32'd2);
        check("jalr_r_b",   {30'd0, h_alu_src_b}, 32'd1);
        check("jalr_r_pcw", {31'd0, h_pc_write}, 32'd0);
        step();
        cyc(1'b1, 4'd10, "jalr_j");
        step();
        cyc(1'b1, 4'd8, "jalr_wb");
        step();
        $display("txn: jalr");

        // LUI
        instr = 32'h0000_10B7;
        step();
        step();
        cyc(1'b1, 4'd12, "lui");
        check("lui_a",   {30'd0, h_alu_src_a}, 32'd3);
        check("lui_imm", {29'd0, h_imm_type}, 32'd4);
        step();
        cyc(1'b1, 4'd8, "lui_wb");
        step();
        $display("txn: lui");

        // Illegal opcode: halting instance stays, running instance recovers
        instr = 32'h0000_007F;
        do_reset();
        cyc(1'b1, 4'd0, "ill_f");
        step();
        cyc(1'b1, 4'd1, "ill_d");
        step();
        cyc(1'b1, 4'd14, "ill_trap");
        check("ill_h_ill",    {31'd0, h_illegal}, 32'd1);
        check("ill_r_ill",    {31'd0, r_illegal}, 32'd1);
        check("ill_r_state",  {28'd0, r_state}, 32'd14);
        check("ill_h_strb",
              {26'd0, h_pc_write, h_ir_write, h_mem_read, h_mem_write, h_reg_write, h_instr_done},
              32'd0);
        step();
        check("ill_r_next",  {28'd0, r_state}, 32'd0);
        check("ill_r_ill0",  {31'd0, r_illegal}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'd14, "ill_hold");
            check("ill_hold_ill", {31'd0, h_illegal}, 32'd1);
            step();
        end
        $display("txn: illegal opcode");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback for each instruction held in the instruction register.
- Drives the datapath mux selects and write strobes, and sets the immediate-variant select for the sign-extension unit.
- Handles variable-latency memory through a ready handshake.

Parameters:
- TRAP_HALT, 1, 1 = stay in TRAP until reset; 0 = leave TRAP after one cycle and re-fetch.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-high
- instr  in  32  instruction register contents; valid from DECODE onward
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  load PC from result bus
- ir_write  out  1  load instruction register from memory data
- adr_src  out  1  memory address: 0 = PC, 1 = ALU-out register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write of rd
- result_src  out  2  result bus: 00 = ALU-out register, 01 = memory data, 10 = ALU result direct
- alu_src_a  out  2  ALU A: 00 = PC, 01 = old PC, 10 = rs1, 11 = zero
- alu_src_b  out  2  ALU B: 00 = rs2, 01 = immediate, 10 = constant 4
- alu_op  out  2  00 = add, 01 = subtract/compare, 10 = decode funct3/funct7
- imm_type  out  3  immediate variant: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- illegal  out  1  high while in TRAP
- instr_done  out  1  one-cycle pulse when an instruction retires
- state  out  4  current state encoding, for debug

Behaviour:
- Moore-style outputs decoded from the state register; the exceptions are the mem_ready-gated strobes, the imm_type selects, and branch pc_write. State updates on posedge clk.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, TRAP=14.
- Encoding 15 is unreachable and falls through to TRAP.
- Reset: state=FETCH. While rst is high, pc_write, ir_write, mem_read, mem_write, reg_write and instr_done are forced to 0. Reset mid-instruction abandons the instruction with no write strobes.
- Default in every state: all strobes 0, all selects 00, imm_type=000, alu_op=00.
- FETCH: mem_read=1, adr_src=0, a=00, b=10, result_src=10.
  - mem_ready=1: ir_write=1 and pc_write=1 in that same cycle, then go to DECODE.
  - mem_ready=0: stay in FETCH with no strobes.
- DECODE: a=01, b=01, alu_op=00; this latches the branch/JAL target in the ALU-out register. imm_type=011 if opcode=1101111, else 010. Dispatch on instr[6:0]:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> TRAP
- MEMADR: a=10, b=01, alu_op=00. imm_type=001 for a store, 000 for a load. Next state is MEMWRITE for a store, MEMREAD for a load.
- MEMREAD: mem_read=1, adr_src=1. Stay until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1, then go to FETCH.
- MEMWRITE: mem_write=1, adr_src=1. Stay until mem_ready; in the mem_ready cycle instr_done=1 and go to FETCH.
- EXECR: a=10, b=00, alu_op=10, then go to ALUWB.
- EXECI: a=10, b=01, alu_op=10, imm_type=000, then go to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1, then go to FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00. instr_done=1, then go to FETCH.
  - pc_write = taken, by funct3: 000 = zero, 001 = !zero, 100 = lt, 101 = !lt, 110 = ltu, 111 = !ltu.
  - funct3 010 or 011 goes to TRAP instead, with no pc_write and no instr_done.
- JALR: a=10, b=01, alu_op=00, imm_type=000, then go to JAL. Clearing target bit 0 is a datapath responsibility.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1, then go to ALUWB (writes old PC+4 to rd).
- LUI: a=11, b=01, imm_type=100, then go to ALUWB.
- AUIPC: a=01, b=01, imm_type=100, then go to ALUWB.
- TRAP: illegal=1 and all strobes 0. TRAP_HALT=1 stays in TRAP; TRAP_HALT=0 goes to FETCH next cycle.
- Cycle counts with zero memory wait:
  - load = 5
  - store = 4
  - R-type, I-type, LUI, AUIPC, JAL = 4
  - branch = 3
  - JALR = 5
- Each memory wait cycle adds 1.

Test Plan:
- Reset asserted mid-MEMREAD, then released; instr=0x00000013 (addi x0,x0,0), mem_ready=1 -> state=FETCH while rst is high with all strobes 0. After release: FETCH, DECODE, EXECI, ALUWB; reg_write=1 and instr_done=1 in cycle 4.
- Load 0x0000A083 (lw x1,0(x1)) with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 3 cycles with mem_read=1 and adr_src=1; MEMWB has result_src=01 and reg_write=1; total 8 cycles.
- Store 0x0020A023 (sw x2,0(x1)) -> imm_type=001 in MEMADR; mem_write=1 in MEMWRITE; reg_write never asserted.
- Branch 0x00208463 (beq):
  - zero=1 -> pc_write=1 in BRANCH.
  - Repeat with zero=0 -> pc_write=0.
  - funct3=010 -> TRAP with illegal=1.
- Jumps:
  - JAL 0x008000EF -> imm_type=011 in DECODE; sequence FETCH, DECODE, JAL, ALUWB.
  - JALR 0x000080E7 -> sequence DECODE, JALR, JAL, ALUWB.
- Opcode 0x0000007F:
  - TRAP_HALT=1 -> illegal stays high indefinitely.
  - TRAP_HALT=0 -> illegal high for 1 cycle, then FETCH.
